// File: rtl/i2s_tx_param_if.sv
// rtl/i2s_tx_param_if.sv - PCM sample stream into the I2S/TDM transmitter FIFO
interface i2s_tx_param_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tready;

    modport master (output s_tdata, output s_tvalid, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/i2s_tx_param.sv
// rtl/i2s_tx_param.sv - parametrised I2S/left-justified/TDM transmitter with sample FIFO
// Optional underrun_cnt output is enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_param #(
    parameter int NUM_CH     = 2,
    parameter int SLOT_W     = 32,
    parameter int SAMPLE_W   = 24,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         fmt_i2s,
    i2s_tx_param_if.slave                s,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    input  logic                         underrun_clr
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                  underrun_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(BCLK_DIV);
    localparam int KW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int SW = $clog2(NUM_CH);

    logic [SAMPLE_W-1:0]             mem_q [FIFO_DEPTH];
    logic [SAMPLE_W-1:0]             mem_d [FIFO_DEPTH];
    logic [AW-1:0]                   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]                   lvl_q, lvl_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] shd_q, shd_d;
    logic [PW-1:0]                   ph_q, ph_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [SW-1:0]                   s_q, s_d;
    logic                            fmt_q, fmt_d, dly_q, dly_d;
    logic                            bclk_q, bclk_d, lr_q, lr_d, sd_q, sd_d;
    logic                            ur_q, ur_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]                     cnt_q, cnt_d;
`endif

    logic                            push, pop, zero_frame, fbit;
    logic [SAMPLE_W-1:0]             cur, shifted;

    always_comb begin
        mem_d = mem_q;
        wr_d = wr_q; rd_d = rd_q; shd_d = shd_q;
        ph_d = ph_q; k_d = k_q; s_d = s_q;
        fmt_d = fmt_q; dly_d = dly_q;
        bclk_d = bclk_q; lr_d = lr_q; sd_d = sd_q;
        pop = 1'b0; zero_frame = 1'b0; cur = '0; shifted = '0; fbit = 1'b0;

        push = s.s_tvalid && (lvl_q < CW'(FIFO_DEPTH));
        if (push) begin
            mem_d[wr_q] = s.s_tdata;
            wr_d = wr_q + AW'(1);
        end

        if (!en) begin
            bclk_d = 1'b0; lr_d = 1'b0; sd_d = 1'b0;
            ph_d = '0; k_d = '0; s_d = '0; dly_d = 1'b0;
        end else begin
            bclk_d = (ph_q >= PW'(BCLK_DIV / 2));
            ph_d = (ph_q == PW'(BCLK_DIV - 1)) ? '0 : ph_q + PW'(1);
            if (ph_q == '0) begin
                // A short FIFO plays silence instead of a partial frame so channels never slip.
                if (s_q == '0 && k_q == '0) begin
                    fmt_d = fmt_i2s;
                    if (lvl_q >= CW'(NUM_CH)) begin
                        pop = 1'b1;
                        for (int i = 0; i < NUM_CH; i++) shd_d[i] = mem_q[rd_q + AW'(i)];
                        rd_d = rd_q + AW'(NUM_CH);
                    end else begin
                        zero_frame = 1'b1;
                        shd_d = '0;
                    end
                end
                cur = shd_d[s_q];
                shifted = cur << k_q;
                fbit = shifted[SAMPLE_W-1];
                // The delay bit always holds the previous bit, carrying the last bit across frames.
                sd_d = fmt_d ? dly_q : fbit;
                dly_d = fbit;
                if (NUM_CH == 2)
                    lr_d = (s_q == SW'(1));
                else if (fmt_d)
                    lr_d = (s_q == SW'(NUM_CH - 1)) && (k_q == KW'(SLOT_W - 1));
                else
                    lr_d = (s_q == '0) && (k_q == '0);
                if (k_q == KW'(SLOT_W - 1)) begin
                    k_d = '0;
                    s_d = (s_q == SW'(NUM_CH - 1)) ? '0 : s_q + SW'(1);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
        end

        lvl_d = lvl_q + CW'(push) - (pop ? CW'(NUM_CH) : CW'(0));
        ur_d = zero_frame ? 1'b1 : (underrun_clr ? 1'b0 : ur_q);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        cnt_d = cnt_q;
        if (zero_frame)
            cnt_d = underrun_clr ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
        else if (underrun_clr)
            cnt_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0; rd_q <= '0; lvl_q <= '0; shd_q <= '0;
            ph_q <= '0; k_q <= '0; s_q <= '0;
            fmt_q <= 1'b0; dly_q <= 1'b0;
            bclk_q <= 1'b0; lr_q <= 1'b0; sd_q <= 1'b0; ur_q <= 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            cnt_q <= '0;
`endif
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d; rd_q <= rd_d; lvl_q <= lvl_d; shd_q <= shd_d;
            ph_q <= ph_d; k_q <= k_d; s_q <= s_d;
            fmt_q <= fmt_d; dly_q <= dly_d;
            bclk_q <= bclk_d; lr_q <= lr_d; sd_q <= sd_d; ur_q <= ur_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign s.s_tready  = (lvl_q < CW'(FIFO_DEPTH));
    assign bclk        = bclk_q;
    assign lrclk       = lr_q;
    assign sdata       = sd_q;
    assign fifo_level  = lvl_q;
    assign underrun    = ur_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    assign underrun_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_i2s_tx_param.sv
// tb/tb_i2s_tx_param.sv - self-checking bench for i2s_tx_param (stereo and 4-slot TDM instances)
module tb_i2s_tx_param;
    localparam int DIV   = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic a_en = 1'b0, a_fmt = 1'b0, a_clr = 1'b0;
    logic b_en = 1'b0, b_fmt = 1'b0, b_clr = 1'b0;
    logic a_bclk, a_lr, a_sd, a_ur;
    logic b_bclk, b_lr, b_sd, b_ur;
    logic [4:0] a_lvl, b_lvl;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [23:0] mq[$];
    bit exp_ur;
    int exp_cnt;

    i2s_tx_param_if #(.SAMPLE_W(24)) a_if ();
    i2s_tx_param_if #(.SAMPLE_W(16)) b_if ();

    i2s_tx_param u_a (
        .clk(clk), .rstn(rstn), .en(a_en), .fmt_i2s(a_fmt), .s(a_if),
        .bclk(a_bclk), .lrclk(a_lr), .sdata(a_sd), .fifo_level(a_lvl),
        .underrun(a_ur), .underrun_clr(a_clr)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(a_cnt)
`endif
    );

    i2s_tx_param #(.NUM_CH(4), .SLOT_W(16), .SAMPLE_W(16), .BCLK_DIV(4), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rstn(rstn), .en(b_en), .fmt_i2s(b_fmt), .s(b_if),
        .bclk(b_bclk), .lrclk(b_lr), .sdata(b_sd), .fifo_level(b_lvl),
        .underrun(b_ur), .underrun_clr(b_clr)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(b_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; reset is asserted mid-cycle to exercise its asynchronous path.
    task automatic do_reset();
        a_en = 1'b0; b_en = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
        a_if.s_tvalid = 1'b0; b_if.s_tvalid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        chk("rst_bclk", a_bclk, 0); chk("rst_lrclk", a_lr, 0); chk("rst_sdata", a_sd, 0);
        chk("rst_level", a_lvl, 0); chk("rst_tready", a_if.s_tready, 1); chk("rst_underrun", a_ur, 0);
        chk("rst_b_level", b_lvl, 0); chk("rst_b_tready", b_if.s_tready, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("rst_cnt", a_cnt, 0);
`endif
        mq.delete(); exp_ur = 1'b0; exp_cnt = 0;
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic push(input bit sel, input logic [23:0] d);
        bit acc;
        acc = (mq.size() < DEPTH);
        if (sel) begin b_if.s_tdata = d[15:0]; b_if.s_tvalid = 1'b1; chk("tready_b", b_if.s_tready, acc); end
        else     begin a_if.s_tdata = d;       a_if.s_tvalid = 1'b1; chk("tready", a_if.s_tready, acc); end
        @(posedge clk); #1;
        a_if.s_tvalid = 1'b0; b_if.s_tvalid = 1'b0;
        if (acc) mq.push_back(sel ? {8'h00, d[15:0]} : d);
    endtask

    task automatic clr_ur(input bit sel);
        if (sel) b_clr = 1'b1; else a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0; b_clr = 1'b0;
        exp_ur = 1'b0; exp_cnt = 0;
        chk("ur_after_clr", sel ? b_ur : a_ur, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("cnt_after_clr", sel ? b_cnt : a_cnt, 0);
`endif
    endtask

    // Plays nframes from the model FIFO, checking every clk; optionally pushes one word during
    // frame 0 and stops early after stop_at observed cycles.
    task automatic run(input bit sel, input int nframes, input bit fmt, input int stop_at,
                       input int push_cyc, input logic [23:0] push_val);
        int nch, slot, sw, fb, tot, j, ph;
        logic [23:0] w [4];
        bit bits [128];
        bit prev, stopped, e_bclk, e_sd, e_lr;
        nch = sel ? 4 : 2; slot = sel ? 16 : 32; sw = sel ? 16 : 24; fb = nch * slot;
        prev = 1'b0; stopped = 1'b0; tot = 0;
        if (sel) begin b_fmt = fmt; b_en = 1'b1; end else begin a_fmt = fmt; a_en = 1'b1; end
        for (int f = 0; f < nframes && !stopped; f++) begin
            if (mq.size() >= nch) begin
                for (int i = 0; i < nch; i++) w[i] = mq.pop_front();
            end else begin
                for (int i = 0; i < 4; i++) w[i] = '0;
                exp_ur = 1'b1;
                if (exp_cnt < 65535) exp_cnt++;
            end
            for (int jj = 0; jj < fb; jj++)
                bits[jj] = ((jj % slot) < sw) ? w[jj / slot][sw - 1 - (jj % slot)] : 1'b0;
            for (int c = 0; c < fb * DIV && !stopped; c++) begin
                @(posedge clk); #1;
                j = c / DIV; ph = c % DIV;
                e_bclk = (ph >= DIV / 2);
                e_sd = fmt ? ((j == 0) ? prev : bits[j - 1]) : bits[j];
                e_lr = (nch == 2) ? ((j / slot) == 1) : (fmt ? (j == fb - 1) : (j == 0));
                chk("bclk", sel ? b_bclk : a_bclk, e_bclk);
                chk("sdata", sel ? b_sd : a_sd, e_sd);
                chk("lrclk", sel ? b_lr : a_lr, e_lr);
                if (c == 0) begin
                    chk("frame_level", sel ? b_lvl : a_lvl, mq.size());
                    chk("frame_underrun", sel ? b_ur : a_ur, exp_ur);
`ifdef I2S_TX_UNDERRUN_CNT_EN
                    chk("frame_cnt", sel ? b_cnt : a_cnt, exp_cnt);
`endif
                end
                if (f == 0 && c == push_cyc) begin
                    if (sel) begin b_if.s_tdata = push_val[15:0]; b_if.s_tvalid = 1'b1; end
                    else     begin a_if.s_tdata = push_val;       a_if.s_tvalid = 1'b1; end
                    if (mq.size() < DEPTH) mq.push_back(sel ? {8'h00, push_val[15:0]} : push_val);
                end else begin
                    a_if.s_tvalid = 1'b0; b_if.s_tvalid = 1'b0;
                end
                tot++;
                if (tot == stop_at) stopped = 1'b1;
            end
            prev = bits[fb - 1];
        end
        a_en = 1'b0; b_en = 1'b0; a_if.s_tvalid = 1'b0; b_if.s_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("stop_bclk", sel ? b_bclk : a_bclk, 0);
        chk("stop_sdata", sel ? b_sd : a_sd, 0);
        chk("stop_lrclk", sel ? b_lr : a_lr, 0);
        chk("stop_level", sel ? b_lvl : a_lvl, mq.size());
    endtask

    initial begin
        a_if.s_tvalid = 1'b0; a_if.s_tdata = '0;
        b_if.s_tvalid = 1'b0; b_if.s_tdata = '0;
        @(posedge clk); #1;
        do_reset();

        // Reset while running with five words queued and underrun set.
        a_fmt = 1'b0; a_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_ur = 1'b1;
        chk("empty_start_underrun", a_ur, 1);
        for (int i = 0; i < 5; i++) push(0, 24'($urandom));
        chk("level_five", a_lvl, 5);
        do_reset();

        // Left-justified stereo, then a zero frame to check wrap without gap.
        push(0, 24'hA5A5A5); push(0, 24'h5A5A5A);
        chk("level_two", a_lvl, 2);
        run(0, 2, 1'b0, -1, -1, '0);
        do_reset();

        // Same samples in I2S mode.
        push(0, 24'hA5A5A5); push(0, 24'h5A5A5A);
        run(0, 2, 1'b1, -1, -1, '0);
        do_reset();

        // Random samples, random format, ending in an underrun frame.
        for (int i = 0; i < 6; i++) push(0, 24'($urandom));
        run(0, 4, 1'($urandom_range(0, 1)), -1, -1, '0);
        do_reset();

        // Underrun with one word queued; second word arrives mid-frame.
        push(0, 24'($urandom));
        run(0, 2, 1'b0, -1, 40, 24'($urandom));
        chk("ur_sticky", a_ur, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("cnt_before_clr", a_cnt, 1);
`endif
        clr_ur(0);
        do_reset();

        // FIFO fill to full while stopped.
        for (int i = 0; i < 17; i++) push(0, 24'($urandom));
        chk("full_level", a_lvl, 16);
        chk("full_tready", a_if.s_tready, 0);
        run(0, 1, 1'($urandom_range(0, 1)), -1, -1, '0);
        do_reset();

        // TDM left-justified, stopped at bclk 20 with one word left in the FIFO.
        push(1, 24'h008001); push(1, 24'h000002); push(1, 24'h000003); push(1, 24'h000004);
        push(1, 24'($urandom));
        run(1, 1, 1'b0, 20 * DIV + 1, -1, '0);
        do_reset();

        // TDM I2S over two frames, the second an underrun.
        for (int i = 0; i < 4; i++) push(1, 24'($urandom));
        run(1, 2, 1'b1, -1, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
